// File: rtl/call_dispatcher.sv
// Floor-call dispatcher: debounces the three call buttons, latches pending calls and
// offers the next target floor to the movement block using SCAN ordering.
module call_dispatcher #(
   parameter int unsigned DEBOUNCE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       button1,
   input  logic       button2,
   input  logic       button3,
   input  logic       floor1,
   input  logic       floor2,
   input  logic       floor3,
   input  logic       door,
   input  logic       moving,
   input  logic       sos_mode,
   output logic       led1,
   output logic       led2,
   output logic       led3,
   output logic [1:0] target,
   output logic       target_valid,
   input  logic       target_ack
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

   typedef enum logic [1:0] {IDLE, OFFER, WAIT_ARRIVE} state_t;

   state_t           state, state_d;
   logic [1:0]       target_d;
   logic             valid_d;
   logic             dir_up, dir_d;
   logic [2:0]       btn, floor_vec;
   logic [2:0]       sync1, sync2, deb, deb_q, rise, serve, pending, pend_other;
   logic [CNT_W-1:0] cnt [3];
   logic             pos_valid, tgt_pend;
   logic [1:0]       cur, up_pick, dn_pick, pick;

   assign btn       = {button3, button2, button1};
   assign floor_vec = {floor3, floor2, floor1};
   assign pos_valid = $onehot(floor_vec);
   assign led1      = pending[0];
   assign led2      = pending[1];
   assign led3      = pending[2];

   // Synchronizers, saturating debounce counters and debounced-level history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
         deb_q <= '0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         deb_q <= deb;
         for (int i = 0; i < 3; i++) begin
            if (!sync2[i])            cnt[i] <= '0;
            else if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) deb[i] = (cnt[i] == CNT_MAX);
   end

   assign rise  = deb & ~deb_q;
   assign serve = (pos_valid && door && !moving) ? floor_vec : 3'b000;

   // Pending calls: serving beats a simultaneous new press; SOS wipes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        pending <= '0;
      else if (sos_mode) pending <= '0;
      else               pending <= (pending | rise) & ~serve;
   end

   // SCAN selection relative to the current floor
   always_comb begin
      cur        = 2'd0;
      up_pick    = 2'd0;
      dn_pick    = 2'd0;
      pend_other = pending & ~floor_vec;
      if (pos_valid) cur = floor1 ? 2'd1 : (floor2 ? 2'd2 : 2'd3);
      case (cur)
         2'd1: up_pick = pend_other[1] ? 2'd2 : (pend_other[2] ? 2'd3 : 2'd0);
         2'd2: begin
            up_pick = pend_other[2] ? 2'd3 : 2'd0;
            dn_pick = pend_other[0] ? 2'd1 : 2'd0;
         end
         2'd3: dn_pick = pend_other[1] ? 2'd2 : (pend_other[0] ? 2'd1 : 2'd0);
         default: ;
      endcase
      if (dir_up) pick = (up_pick != 2'd0) ? up_pick : dn_pick;
      else        pick = (dn_pick != 2'd0) ? dn_pick : up_pick;
   end

   always_comb begin
      case (target)
         2'd1:    tgt_pend = pending[0];
         2'd2:    tgt_pend = pending[1];
         2'd3:    tgt_pend = pending[2];
         default: tgt_pend = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         target       <= 2'd0;
         target_valid <= 1'b0;
         dir_up       <= 1'b1;
      end else begin
         state        <= state_d;
         target       <= target_d;
         target_valid <= valid_d;
         dir_up       <= dir_d;
      end
   end

   always_comb begin
      state_d  = state;
      target_d = target;
      dir_d    = dir_up;
      valid_d  = 1'b0;
      if (sos_mode) begin
         state_d  = IDLE;
         target_d = 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (pos_valid && !moving && pick != 2'd0) begin
                  state_d  = OFFER;
                  target_d = pick;
                  dir_d    = (pick > cur);
               end
            end
            OFFER: begin
               // A call served before acknowledgement withdraws the offer
               if (!tgt_pend)       state_d = IDLE;
               else if (target_ack) state_d = WAIT_ARRIVE;
            end
            WAIT_ARRIVE: begin
               if (!tgt_pend) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      valid_d = (state_d == OFFER);
   end

endmodule

// File: tb/tb_call_dispatcher.sv
// Randomized and directed bench for call_dispatcher against a behavioural call/scan model.
module tb_call_dispatcher;

   localparam int unsigned D = 3;
   localparam int M_IDLE = 0;
   localparam int M_OFFER = 1;
   localparam int M_WAIT = 2;

   logic       clk;
   logic       rst_n;
   logic       button1, button2, button3;
   logic       floor1, floor2, floor3;
   logic       door, moving, sos_mode, target_ack;
   logic       led1, led2, led3;
   logic [1:0] target;
   logic       target_valid;

   call_dispatcher #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst_n(rst_n),
      .button1(button1), .button2(button2), .button3(button3),
      .floor1(floor1), .floor2(floor2), .floor3(floor3),
      .door(door), .moving(moving), .sos_mode(sos_mode),
      .led1(led1), .led2(led2), .led3(led3),
      .target(target), .target_valid(target_valid), .target_ack(target_ack)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   bit [2:0] m_s1, m_s2, m_dq, m_pend;
   int       m_cnt [3];
   int       m_st, m_tgt;
   bit       m_tv, m_up;
   bit [2:0] m_raw, m_fl, m_deb, m_rise, m_serve, m_pn;
   bit       m_valid;
   int       m_cur, m_pick;

   // Nearest pending floor in the travel direction, else nearest the other way
   function automatic int scan_pick(input int cur, input bit up, input bit [2:0] p);
      int d;
      d = up ? 1 : -1;
      for (int k = 0; k < 2; k++) begin
         for (int f = cur + d; f >= 1 && f <= 3; f += d)
            if (p[f-1]) return f;
         d = -d;
      end
      return 0;
   endfunction

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_s1 = 0; m_s2 = 0; m_dq = 0; m_pend = 0;
            for (int i = 0; i < 3; i++) m_cnt[i] = 0;
            m_st = M_IDLE; m_tgt = 0; m_tv = 0; m_up = 1;
         end else begin
            m_raw   = {button3, button2, button1};
            m_fl    = {floor3, floor2, floor1};
            m_valid = ($countones(m_fl) == 1);
            m_cur   = !m_valid ? 0 : (m_fl[0] ? 1 : (m_fl[1] ? 2 : 3));
            for (int i = 0; i < 3; i++) begin
               m_deb[i]   = (m_cnt[i] >= D);
               m_rise[i]  = m_deb[i] && !m_dq[i];
               m_serve[i] = m_valid && door && !moving && (m_cur == i + 1);
            end
            m_pn = sos_mode ? 3'b000 : ((m_pend | m_rise) & ~m_serve);
            if (sos_mode) begin
               m_st = M_IDLE; m_tgt = 0; m_tv = 0;
            end else if (m_st == M_IDLE) begin
               if (m_valid && !moving) begin
                  m_pick = scan_pick(m_cur, m_up, m_pend & ~m_fl);
                  if (m_pick != 0) begin
                     m_st = M_OFFER; m_tgt = m_pick; m_tv = 1; m_up = (m_pick > m_cur);
                  end
               end
            end else if (m_st == M_OFFER) begin
               if (!m_pend[m_tgt-1])  begin m_st = M_IDLE; m_tv = 0; end
               else if (target_ack)   begin m_st = M_WAIT; m_tv = 0; end
            end else begin
               if (!m_pend[m_tgt-1]) m_st = M_IDLE;
            end
            for (int i = 0; i < 3; i++)
               m_cnt[i] = m_s2[i] ? ((m_cnt[i] < D) ? m_cnt[i] + 1 : D) : 0;
            m_dq = m_deb; m_s2 = m_s1; m_s1 = m_raw; m_pend = m_pn;
         end
      end
   end

   // Cycle-by-cycle comparison against the model
   always @(negedge clk) begin
      check("leds", 8'({led3, led2, led1}), 8'(m_pend));
      check("target", 8'(target), 8'(m_tgt));
      check("target_valid", 8'(target_valid), 8'(m_tv));
   end

   task automatic set_floor(input bit [2:0] f);
      {floor3, floor2, floor1} = f;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_tv(input int budget);
      for (int i = 0; i < budget && target_valid !== 1'b1; i++) @(negedge clk);
   endtask

   bit [2:0] rb;
   int       r;

   initial begin
      rst_n = 1'b0;
      {button3, button2, button1} = 3'b000;
      set_floor(3'b001);
      door = 0; moving = 0; sos_mode = 0; target_ack = 0;
      #1;
      check("rst_leds", 8'({led3, led2, led1}), 8'h0);
      check("rst_target", 8'(target), 8'h0);
      check("rst_valid", 8'(target_valid), 8'h0);
      cycles(2);
      rst_n = 1'b1;
      cycles(6);

      // Car at floor1, hold button3: led after 6 edges, offer on the 7th
      button3 = 1;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         if (k == 5) check("led3_early", 8'(led3), 8'h0);
         if (k == 6) begin
            check("led3_lat", 8'(led3), 8'h1);
            check("tv_before", 8'(target_valid), 8'h0);
         end
         if (k == 7) begin
            check("offer_tv", 8'(target_valid), 8'h1);
            check("offer_tgt", 8'(target), 8'h3);
         end
      end
      cycles(3);
      check("hold_tgt", 8'({target_valid, target}), 8'h7);
      target_ack = 1;
      cycles(1);
      target_ack = 0;
      check("ack_drop", 8'(target_valid), 8'h0);

      // Moving up with pending 3, new call at 2; serve 3 then offer 2 going down
      button3 = 0; moving = 1;
      button2 = 1;
      cycles(7);
      check("led2_set", 8'(led2), 8'h1);
      button2 = 0;
      set_floor(3'b100); moving = 0; door = 1;
      cycles(1);
      check("led3_served", 8'(led3), 8'h0);
      wait_tv(6);
      check("down_tv", 8'(target_valid), 8'h1);
      check("down_tgt", 8'(target), 8'h2);
      door = 0;
      target_ack = 1;
      cycles(1);
      target_ack = 0;
      cycles(2);

      // Asynchronous reset in the middle of WAIT_ARRIVE
      #2 rst_n = 1'b0;
      #1;
      check("arst_out", 8'({target_valid, target, led3, led2, led1}), 8'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(6);

      // Glitch, long hold, serve while held, re-press
      set_floor(3'b010); moving = 1;
      button1 = 1; cycles(2); button1 = 0; cycles(8);
      check("glitch", 8'(led1), 8'h0);
      button1 = 1; cycles(20);
      check("hold_once", 8'(led1), 8'h1);
      set_floor(3'b001); door = 1; moving = 0;
      cycles(2);
      check("hold_served", 8'(led1), 8'h0);
      cycles(6);
      check("no_relatch", 8'(led1), 8'h0);
      button1 = 0; set_floor(3'b010); door = 0; moving = 1;
      cycles(3);
      button1 = 1; cycles(8); button1 = 0;
      check("repress", 8'(led1), 8'h1);

      // Press at the floor being served never lights
      door = 1; moving = 0;
      button2 = 1; cycles(10); button2 = 0;
      check("clear_wins", 8'(led2), 8'h0);

      // SOS while offering with calls at 1 and 3
      door = 0;
      button3 = 1; cycles(8); button3 = 0;
      wait_tv(6);
      check("pre_sos_tv", 8'(target_valid), 8'h1);
      sos_mode = 1;
      cycles(1);
      check("sos_out", 8'({target_valid, target, led3, led2, led1}), 8'h0);
      button2 = 1; cycles(8);
      sos_mode = 0; cycles(8);
      check("sos_ignored", 8'(led2), 8'h0);
      button2 = 0; cycles(3);
      button2 = 1; cycles(8); button2 = 0;
      check("sos_fresh", 8'(led2), 8'h1);

      // Invalid position blocks the offer until one-hot again
      set_floor(3'b011); moving = 0;
      cycles(6);
      check("invalid_pos", 8'(target_valid), 8'h0);
      set_floor(3'b001);
      wait_tv(4);
      check("valid_pos", 8'({target_valid, target}), 8'h6);

      // Randomized traffic
      rb = 3'b000;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 5) == 0) rb[b] = ~rb[b];
         {button3, button2, button1} = rb;
         if ($urandom_range(0, 9) == 0) begin
            r = int'($urandom_range(0, 9));
            case (r)
               0, 1, 2: set_floor(3'b001);
               3, 4, 5: set_floor(3'b010);
               6, 7:    set_floor(3'b100);
               8:       set_floor(3'b011);
               default: set_floor(3'b000);
            endcase
         end
         door       = ($urandom_range(0, 3) == 0);
         moving     = ($urandom_range(0, 2) == 0);
         target_ack = ($urandom_range(0, 2) == 0);
         if (sos_mode) sos_mode = ($urandom_range(0, 7) != 0);
         else          sos_mode = ($urandom_range(0, 149) == 0);
      end
      cycles(2);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/call_dispatcher.md
CALL_DISPATCHER -- requirements
Module: call_dispatcher

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 3: consecutive clk cycles a synchronized button must stay high before it counts as a press.
REQ-002 clk  input  1  system clock; the divided elevator clock; all logic rising-edge.
REQ-003 rst_n  input  1  reset; one clock; asynchronous, active-low.
REQ-004 button1, button2, button3  input  1 each  raw floor-call buttons, active-high, asynchronous to clk.
REQ-005 floor1, floor2, floor3  input  1 each  current car position from the movement block, one-hot.
REQ-006 door  input  1  1 = door open.
REQ-007 moving  input  1  1 = car in motion.
REQ-008 sos_mode  input  1  1 = emergency active.
REQ-009 led1, led2, led3  output  1 each  pending-call indicators; ledN equals pending[N].
REQ-010 target  output  2  requested floor: 1, 2 or 3. Value 0 only when target_valid=0.
REQ-011 target_valid  output  1  target offer to the movement block.
REQ-012 target_ack  input  1  movement block accepts the offered target.

Function
REQ-013 Each button SHALL pass through a two-flop synchronizer, then through a per-button saturating counter of width ceil(log2(DEBOUNCE_CYCLES+1)).
- The counter increments while the synchronized bit is 1 and clears to 0 when it is 0.
- The debounced level is 1 when the counter equals DEBOUNCE_CYCLES.
REQ-014 A 0->1 transition of a debounced level SHALL set pending[N] on the next clk edge.
- A button held high produces exactly one press.
- Minimum press-to-led latency is 2+DEBOUNCE_CYCLES+1 cycles.
REQ-015 pending[N] SHALL clear on the clk edge where floorN=1, door=1 and moving=0 (call served).
- If set and clear occur in the same cycle, clear wins.
REQ-016 The position SHALL be valid only when exactly one floor input is 1.
- Invalid position: no clear, no new offer.
- Pending bits are held.
REQ-017 A direction register (UP/DOWN) SHALL drive target selection (SCAN):
- Pick the nearest pending floor strictly ahead of the car in the current direction.
- If none is ahead, toggle the direction and pick the nearest pending floor in the new direction.
- A pending call at the current floor is never offered; it is served by REQ-015.
REQ-018 The FSM SHALL have three states: IDLE, OFFER, WAIT_ARRIVE.
REQ-019 IDLE -> OFFER when all of the following hold: some pending bit (other than the current floor) is set, the position is valid, moving=0 and sos_mode=0.
- On this transition, target is registered.
REQ-020 In OFFER, target_valid=1 and target SHALL hold stable until target_ack=1.
- On target_ack, the FSM goes to WAIT_ARRIVE and deasserts target_valid on the same edge.
- If pending[target] clears while in OFFER, the FSM returns to IDLE without the ack.
REQ-021 In WAIT_ARRIVE, target_valid=0; the FSM returns to IDLE on the edge after pending[target] clears.
- New presses are latched meanwhile but do not alter target.
REQ-022 target_ack SHALL be ignored outside OFFER.
REQ-023 sos_mode=1 SHALL have the following effects:
- All pending bits are cleared.
- Debounced rising edges are ignored.
- The FSM is forced to IDLE with target_valid=0 and target=0 on the next edge.
- Debounce counters keep running, so a button held through SOS exit is not re-latched.
REQ-024 After sos_mode falls, only new debounced rising edges set pending bits.

Reset
REQ-025 While rst_n=0, the following SHALL hold asynchronously:
- synchronizers, debounce counters and pending = 0;
- led1..3 = 0;
- target = 0, target_valid = 0;
- direction = UP;
- FSM = IDLE.
REQ-026 Reset mid-OFFER or mid-WAIT_ARRIVE SHALL drop target_valid immediately; no call survives reset.
REQ-027 The first press is recognized only after rst_n has been high for at least 2+DEBOUNCE_CYCLES cycles.

Verification
REQ-028 Car at floor1, door=0, moving=0: hold button3 for 6 cycles ->
- led3=1 at cycle 6 (DEBOUNCE_CYCLES=3);
- target_valid=1 with target=3 next cycle;
- target held until target_ack pulse, then target_valid=0.
REQ-029 Car moving up from floor1 with pending 3; press button2 ->
- led2=1;
- after floor3 is served (floor3=1, door=1, moving=0): led3=0, then offer target=2 with direction=DOWN.
REQ-030 Glitch: button1 high for 2 cycles, then low -> led1 stays 0.
- Button held 20 cycles -> exactly one latch; after clearing, led1 stays 0 until release and re-press.
REQ-031 At floor2, door=1, moving=0: press button2 -> led2 never asserts (clear wins).
REQ-032 Pending 1 and 3, state OFFER; sos_mode=1 ->
- next edge: led1..3=0, target_valid=0, target=0;
- presses during SOS are ignored;
- after sos_mode=0, a fresh press is accepted.
REQ-033 rst_n pulled low asynchronously during WAIT_ARRIVE -> all outputs 0 before the next clk edge.
- Floor inputs 3'b011 with pending 2 -> no offer until the position becomes one-hot.
